// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path: state
// encodings, instruction class codes, HALT opcode and bus widths.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLASS_CTL  = 2'b00,
        CLASS_ALU  = 2'b01,
        CLASS_FILE = 2'b10,
        CLASS_JUMP = 2'b11
    } instr_class_t;

    localparam logic [3:0] OP_HALT = 4'b1111;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[15:14] == CLASS_CTL) && (word[13:10] == OP_HALT);
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load (jump target) has priority over the
// modulo-256 increment.
module program_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= '0;
        end else if (load) begin
            pc_reg <= load_addr;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch/decode sequencer: reads one instruction word per pass through
// FETCH-DECODE-EXEC-WB and advances or reloads the program counter.
module instruction_fetch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               ir_en,
    input  logic               jump,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    state_t             state_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               mem_req_reg;
    logic               ir_en_reg;
    logic               busy_reg;
    logic               halted_reg;
    logic               pc_inc;
    logic               pc_load;

    // jump is only meaningful on the WB exit edge
    assign pc_load = (state_reg == ST_WB) && jump;
    assign pc_inc  = (state_reg == ST_WB) && !jump;

    program_counter u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (instr_reg[ADDR_W-1:0]),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            mem_req_reg <= 1'b0;
            ir_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            ir_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_reg   <= ST_FETCH;
                        mem_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        halted_reg  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        instr_reg   <= mem_data;
                        state_reg   <= ST_DECODE;
                        mem_req_reg <= 1'b0;
                        ir_en_reg   <= 1'b1;
                    end
                end
                ST_DECODE: state_reg <= ST_EXEC;
                ST_EXEC:   state_reg <= ST_WB;
                ST_WB: begin
                    // pc advances on this same edge, so HALTED resumes past the HALT
                    if (is_halt(instr_reg)) begin
                        state_reg  <= ST_HALTED;
                        busy_reg   <= 1'b0;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg   <= ST_FETCH;
                        mem_req_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = pc;
    assign mem_req  = mem_req_reg;
    assign instr    = instr_reg;
    assign ir_en    = ir_en_reg;
    assign busy     = busy_reg;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural memory answers fetches,
// and each decode strobe is checked against the expected fetch queue.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] instr;
    logic        ir_en;
    logic        jump = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    instruction_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .instr    (instr),
        .ir_en    (ir_en),
        .jump     (jump),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    int          jmode [256];   // 0 none, 1 jump in WB, 2 jump in EXEC only
    int          mem_delay = 0;
    bit          stray = 1'b0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        int          run;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] w, input int r);
        exp_t e;
        e.addr = a;
        e.word = w;
        e.run  = r;
        sb_q.push_back(e);
    endtask

    // memory responder: ack after mem_delay waiting cycles, plus forced stray acks
    int mcnt = 0;
    always @(negedge clk) begin
        if (!mem_req) begin
            mcnt     = 0;
            mem_ack  = stray;
            mem_data = stray ? 16'hBEEF : 16'h0000;
        end else begin
            mem_ack  = (mcnt == mem_delay) || stray;
            mem_data = stray ? 16'hBEEF : mem[mem_addr];
            mcnt++;
        end
    end

    // decoder stand-in: phase 1 DECODE, 2 EXEC, 3 WB
    int ph = 0;
    always @(negedge clk) begin
        if (!rst)                 ph = 0;
        else if (ir_en)           ph = 1;
        else if (ph > 0 && ph < 3) ph++;
        else                      ph = 0;
        jump = (ph == 2 && jmode[pc] == 2) || (ph == 3 && jmode[pc] == 1);
    end

    // monitor: measure each request, compare at the decode strobe
    int         run = 0;
    logic [7:0] run_addr = 8'h0;
    bit         unsteady = 1'b0;
    bit         prev_ir = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            run = 0;
            unsteady = 1'b0;
            prev_ir = 1'b0;
        end else begin
            if (mem_req) begin
                if (run > 0 && mem_addr !== run_addr) unsteady = 1'b1;
                run_addr = mem_addr;
                run++;
            end
            if (ir_en) begin
                chk("ir_en_single", 32'(prev_ir), 32'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_decode: got instr %0h at pc %0h want none", instr, pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("fetch_addr", 32'(pc), 32'(e.addr));
                    chk("fetch_instr", 32'(instr), 32'(e.word));
                    chk("req_cycles", 32'(run), 32'(e.run));
                    chk("addr_steady", 32'(unsteady), 32'd0);
                end
                run = 0;
                unsteady = 1'b0;
            end
            prev_ir = ir_en;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int req_seen;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'h0000;
            jmode[i] = 0;
        end
        mem[8'h00] = 16'h4400;
        mem[8'h01] = 16'h3C00;
        mem[8'h02] = 16'h4401;
        mem[8'h03] = 16'h3C00;
        mem[8'h04] = 16'hC025; jmode[8'h04] = 1;
        mem[8'h25] = 16'hC010; jmode[8'h25] = 2;
        mem[8'h26] = 16'h3C00;
        mem[8'h27] = 16'hC0FF; jmode[8'h27] = 1;
        mem[8'hFF] = 16'h4402;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_instr", 32'(instr), 32'h0000);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir_en", 32'(ir_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // zero-wait fetch of 0x4400 then HALT; 4 cycles per instruction
        mem_delay = 0;
        push(8'h00, 16'h4400, 1);
        push(8'h01, 16'h3C00, 1);
        pulse_start();
        wait_halt(100, cyc);
        chk("period_2instr", 32'(cyc), 32'd8);
        chk("halt_pc", 32'(pc), 32'h02);
        chk("halt_busy", 32'(busy), 32'd0);
        req_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        chk("halted_no_req", 32'(req_seen), 32'd0);

        // three wait states, start held while busy
        mem_delay = 3;
        push(8'h02, 16'h4401, 4);
        push(8'h03, 16'h3C00, 4);
        pulse_start();
        repeat (6) @(negedge clk) start = 1'b1;
        start = 1'b0;
        wait_halt(200, cyc);
        chk("wait_pc", 32'(pc), 32'h04);

        // jump in WB taken, jump in EXEC ignored
        mem_delay = 0;
        push(8'h04, 16'hC025, 1);
        push(8'h25, 16'hC010, 1);
        push(8'h26, 16'h3C00, 1);
        pulse_start();
        wait_halt(200, cyc);
        chk("jump_pc", 32'(pc), 32'h27);

        // pc wrap from 0xFF
        push(8'h27, 16'hC0FF, 1);
        push(8'hFF, 16'h4402, 1);
        push(8'h00, 16'h4400, 1);
        push(8'h01, 16'h3C00, 1);
        pulse_start();
        wait_halt(200, cyc);
        chk("wrap_pc", 32'(pc), 32'h02);

        // reset mid-FETCH, then stray acks while idle
        mem_delay = 5;
        pulse_start();
        chk("mid_fetch_req", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_pc", 32'(pc), 32'h00);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_instr", 32'(instr), 32'h0000);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_instr", 32'(instr), 32'h0000);
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_req", 32'(mem_req), 32'd0);

        mem_delay = 0;
        push(8'h00, 16'h4400, 1);
        push(8'h01, 16'h3C00, 1);
        pulse_start();
        wait_halt(200, cyc);
        chk("restart_pc", 32'(pc), 32'h02);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
